id_decoder: RTL and testbench



---
 rtl/id_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_id_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decoder.sv
// Instruction decode: field split, EX/MEM forwarding, branch resolve, decode exceptions, load-use detect.
// Latency: read addresses and ld_hazard are combinational, decode bundle 1 cycle; no handshake, a load-use hit registers a bubble.
module id_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] if_pc,
  input  logic [31:0] if_insn,
  input  logic [31:0] gpr_rd_data_0,
  input  logic [31:0] gpr_rd_data_1,
  input  logic        id_en_,
  input  logic        id_gpr_we_,
  input  logic [4:0]  id_dst_addr,
  input  logic [1:0]  id_mem_op,
  input  logic [31:0] ex_fwd_data,
  input  logic        ex_en_,
  input  logic        ex_gpr_we_,
  input  logic [4:0]  ex_dst_addr,
  input  logic [31:0] mem_fwd_data,
  input  logic        exe_mode,
  input  logic [31:0] creg_rd_data,
  output logic [4:0]  gpr_rd_addr_0,
  output logic [4:0]  gpr_rd_addr_1,
  output logic [4:0]  creg_rd_addr,
  output logic        ld_hazard,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_in_0,
  output logic [31:0] alu_in_1,
  output logic [29:0] br_addr,
  output logic        br_taken,
  output logic        br_flag,
  output logic [1:0]  mem_op,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  ctrl_op,
  output logic [4:0]  dst_addr,
  output logic        gpr_we_,
  output logic [2:0]  exp_code
);

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_AND = 4'd1, ALU_OR = 4'd2, ALU_XOR = 4'd3,
                         ALU_ADDS = 4'd4, ALU_ADDU = 4'd5, ALU_SUBS = 4'd6, ALU_SUBU = 4'd7,
                         ALU_SHRL = 4'd8, ALU_SHLL = 4'd9;
  localparam logic [1:0] MEM_NOP = 2'd0, MEM_LDW = 2'd1, MEM_STW = 2'd2;
  localparam logic [1:0] CTRL_NOP = 2'd0, CTRL_WRCR = 2'd1, CTRL_EXRT = 2'd2;
  localparam logic [2:0] EXP_NO = 3'd0, EXP_UNDEF = 3'd2, EXP_TRAP = 3'd5, EXP_PRV = 3'd6;

  logic [5:0]  op;
  logic [4:0]  ra_addr, rb_addr, rc_addr;
  logic [15:0] imm;
  logic [31:0] ra_data, rb_data, imm_s, imm_u;
  logic [29:0] br_tgt;

  assign op      = if_insn[31:26];
  assign ra_addr = if_insn[25:21];
  assign rb_addr = if_insn[20:16];
  assign rc_addr = if_insn[15:11];
  assign imm     = if_insn[15:0];
  assign imm_s   = {{16{imm[15]}}, imm};
  assign imm_u   = {16'h0000, imm};
  assign br_tgt  = if_pc + {{14{imm[15]}}, imm};

  assign gpr_rd_addr_0 = ra_addr;
  assign gpr_rd_addr_1 = rb_addr;
  assign creg_rd_addr  = ra_addr;

  // EX result is younger than MEM result, so it wins when both target the same register.
  always_comb begin
    ra_data = gpr_rd_data_0;
    rb_data = gpr_rd_data_1;
    if (!id_en_ && !id_gpr_we_ && id_dst_addr == ra_addr)      ra_data = ex_fwd_data;
    else if (!ex_en_ && !ex_gpr_we_ && ex_dst_addr == ra_addr) ra_data = mem_fwd_data;
    if (!id_en_ && !id_gpr_we_ && id_dst_addr == rb_addr)      rb_data = ex_fwd_data;
    else if (!ex_en_ && !ex_gpr_we_ && ex_dst_addr == rb_addr) rb_data = mem_fwd_data;
  end

  assign ld_hazard = !id_en_ && !id_gpr_we_ && id_mem_op == MEM_LDW &&
                     (id_dst_addr == ra_addr || id_dst_addr == rb_addr);

  logic [3:0]  alu_op_d, alu_op_q;
  logic [31:0] alu_in_0_d, alu_in_0_q, alu_in_1_d, alu_in_1_q, mem_wr_data_d, mem_wr_data_q;
  logic [29:0] br_addr_d, br_addr_q;
  logic        br_taken_d, br_taken_q, br_flag_d, br_flag_q, gpr_we_d, gpr_we_q;
  logic [1:0]  mem_op_d, mem_op_q, ctrl_op_d, ctrl_op_q;
  logic [4:0]  dst_addr_d, dst_addr_q;
  logic [2:0]  exp_code_d, exp_code_q;

  always_comb begin
    alu_op_d      = ALU_NOP;
    alu_in_0_d    = ra_data;
    alu_in_1_d    = rb_data;
    br_addr_d     = 30'd0;
    br_taken_d    = 1'b0;
    br_flag_d     = 1'b0;
    mem_op_d      = MEM_NOP;
    mem_wr_data_d = rb_data;
    ctrl_op_d     = CTRL_NOP;
    dst_addr_d    = 5'd0;
    gpr_we_d      = 1'b1;
    exp_code_d    = EXP_NO;

    // Opcodes 00-0F are ALU ops; odd ones (except SUBUR) take an immediate and write rb.
    if (op[5:4] == 2'b00) begin
      gpr_we_d = 1'b0;
      if (op[0] && op != 6'h0B) begin
        dst_addr_d = rb_addr;
        alu_in_1_d = (op == 6'h07 || op == 6'h09) ? imm_s : imm_u;
      end else begin
        dst_addr_d = rc_addr;
      end
    end

    case (op)
      6'h00, 6'h01: alu_op_d = ALU_AND;
      6'h02, 6'h03: alu_op_d = ALU_OR;
      6'h04, 6'h05: alu_op_d = ALU_XOR;
      6'h06, 6'h07: alu_op_d = ALU_ADDS;
      6'h08, 6'h09: alu_op_d = ALU_ADDU;
      6'h0A:        alu_op_d = ALU_SUBS;
      6'h0B:        alu_op_d = ALU_SUBU;
      6'h0C, 6'h0D: alu_op_d = ALU_SHRL;
      6'h0E, 6'h0F: alu_op_d = ALU_SHLL;
      6'h10, 6'h11, 6'h12, 6'h13: begin
        br_flag_d = 1'b1;
        br_addr_d = br_tgt;
        case (op[1:0])
          2'b00:   br_taken_d = (ra_data == rb_data);
          2'b01:   br_taken_d = (ra_data != rb_data);
          2'b10:   br_taken_d = ($signed(ra_data) > $signed(rb_data));
          default: br_taken_d = (ra_data > rb_data);
        endcase
      end
      6'h14, 6'h15: begin
        br_addr_d  = ra_data[31:2];
        br_taken_d = 1'b1;
        br_flag_d  = 1'b1;
        if (op[0]) begin
          alu_in_0_d = {if_pc + 30'd1, 2'b00};
          dst_addr_d = 5'd31;
          gpr_we_d   = 1'b0;
        end
      end
      6'h16, 6'h17: begin
        alu_op_d   = ALU_ADDU;
        alu_in_1_d = imm_s;
        mem_op_d   = op[0] ? MEM_STW : MEM_LDW;
        if (!op[0]) begin
          dst_addr_d = rb_addr;
          gpr_we_d   = 1'b0;
        end
      end
      6'h18: exp_code_d = EXP_TRAP;
      6'h19, 6'h1A, 6'h1B: begin
        if (exe_mode) begin
          exp_code_d = EXP_PRV;
        end else if (op == 6'h19) begin
          alu_in_0_d = creg_rd_data;
          dst_addr_d = rb_addr;
          gpr_we_d   = 1'b0;
        end else if (op == 6'h1A) begin
          ctrl_op_d  = CTRL_WRCR;
          dst_addr_d = rb_addr;
        end else begin
          ctrl_op_d  = CTRL_EXRT;
        end
      end
      default: exp_code_d = EXP_UNDEF;
    endcase

    // A stalled instruction is replaced by a do-nothing bundle with the default operands.
    if (ld_hazard) begin
      alu_op_d      = ALU_NOP;
      alu_in_0_d    = ra_data;
      alu_in_1_d    = rb_data;
      br_addr_d     = 30'd0;
      br_taken_d    = 1'b0;
      br_flag_d     = 1'b0;
      mem_op_d      = MEM_NOP;
      mem_wr_data_d = rb_data;
      ctrl_op_d     = CTRL_NOP;
      dst_addr_d    = 5'd0;
      gpr_we_d      = 1'b1;
      exp_code_d    = EXP_NO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op_q      <= ALU_NOP;
      alu_in_0_q    <= 32'd0;
      alu_in_1_q    <= 32'd0;
      br_addr_q     <= 30'd0;
      br_taken_q    <= 1'b0;
      br_flag_q     <= 1'b0;
      mem_op_q      <= MEM_NOP;
      mem_wr_data_q <= 32'd0;
      ctrl_op_q     <= CTRL_NOP;
      dst_addr_q    <= 5'd0;
      gpr_we_q      <= 1'b1;
      exp_code_q    <= EXP_NO;
    end else begin
      alu_op_q      <= alu_op_d;
      alu_in_0_q    <= alu_in_0_d;
      alu_in_1_q    <= alu_in_1_d;
      br_addr_q     <= br_addr_d;
      br_taken_q    <= br_taken_d;
      br_flag_q     <= br_flag_d;
      mem_op_q      <= mem_op_d;
      mem_wr_data_q <= mem_wr_data_d;
      ctrl_op_q     <= ctrl_op_d;
      dst_addr_q    <= dst_addr_d;
      gpr_we_q      <= gpr_we_d;
      exp_code_q    <= exp_code_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_in_0    = alu_in_0_q;
  assign alu_in_1    = alu_in_1_q;
  assign br_addr     = br_addr_q;
  assign br_taken    = br_taken_q;
  assign br_flag     = br_flag_q;
  assign mem_op      = mem_op_q;
  assign mem_wr_data = mem_wr_data_q;
  assign ctrl_op     = ctrl_op_q;
  assign dst_addr    = dst_addr_q;
  assign gpr_we_     = gpr_we_q;
  assign exp_code    = exp_code_q;

endmodule

// File: tb/tb_id_decoder.sv
// Bench for id_decoder: directed cases plus random instructions scored against a per-opcode reference table.
module tb_id_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] if_pc;
  logic [31:0] if_insn, gpr_rd_data_0, gpr_rd_data_1;
  logic        id_en_, id_gpr_we_;
  logic [4:0]  id_dst_addr;
  logic [1:0]  id_mem_op;
  logic [31:0] ex_fwd_data;
  logic        ex_en_, ex_gpr_we_;
  logic [4:0]  ex_dst_addr;
  logic [31:0] mem_fwd_data;
  logic        exe_mode;
  logic [31:0] creg_rd_data;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1, creg_rd_addr;
  logic        ld_hazard;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_0, alu_in_1, mem_wr_data;
  logic [29:0] br_addr;
  logic        br_taken, br_flag, gpr_we_;
  logic [1:0]  mem_op, ctrl_op;
  logic [4:0]  dst_addr;
  logic [2:0]  exp_code;

  id_decoder dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_insn(if_insn),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .id_en_(id_en_), .id_gpr_we_(id_gpr_we_), .id_dst_addr(id_dst_addr), .id_mem_op(id_mem_op),
    .ex_fwd_data(ex_fwd_data), .ex_en_(ex_en_), .ex_gpr_we_(ex_gpr_we_), .ex_dst_addr(ex_dst_addr),
    .mem_fwd_data(mem_fwd_data), .exe_mode(exe_mode), .creg_rd_data(creg_rd_data),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1), .creg_rd_addr(creg_rd_addr),
    .ld_hazard(ld_hazard), .alu_op(alu_op), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
    .br_addr(br_addr), .br_taken(br_taken), .br_flag(br_flag), .mem_op(mem_op),
    .mem_wr_data(mem_wr_data), .ctrl_op(ctrl_op), .dst_addr(dst_addr), .gpr_we_(gpr_we_),
    .exp_code(exp_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] in0, in1, wr;
    logic [29:0] br;
    logic        taken, flag, we_;
    logic [1:0]  mem, ctrl;
    logic [4:0]  dst;
    logic [2:0]  exc;
  } exp_t;

  // alu_op for opcodes 0x00..0x0F
  localparam int ALU_TBL [16] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 7, 8, 8, 9, 9};

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (!id_en_ && !id_gpr_we_ && id_dst_addr == a) return ex_fwd_data;
    if (!ex_en_ && !ex_gpr_we_ && ex_dst_addr == a) return mem_fwd_data;
    return rf;
  endfunction

  function automatic logic model_hazard();
    return !id_en_ && !id_gpr_we_ && id_mem_op == 2'd1 &&
           (id_dst_addr == if_insn[25:21] || id_dst_addr == if_insn[20:16]);
  endfunction

  function automatic exp_t model();
    exp_t e;
    int op;
    logic [31:0] a, b, imm_s, imm_u;
    logic [29:0] off;
    op    = int'(if_insn[31:26]);
    a     = fwd(if_insn[25:21], gpr_rd_data_0);
    b     = fwd(if_insn[20:16], gpr_rd_data_1);
    imm_s = {{16{if_insn[15]}}, if_insn[15:0]};
    imm_u = {16'h0, if_insn[15:0]};
    off   = {{14{if_insn[15]}}, if_insn[15:0]};
    e = '{alu: 4'd0, in0: a, in1: b, wr: b, br: 30'd0, taken: 1'b0, flag: 1'b0,
          we_: 1'b1, mem: 2'd0, ctrl: 2'd0, dst: 5'd0, exc: 3'd0};
    if (reset) begin
      e.in0 = 32'd0; e.in1 = 32'd0; e.wr = 32'd0;
      return e;
    end
    if (model_hazard()) return e;
    if (op < 16) begin
      e.alu = 4'(ALU_TBL[op]);
      e.we_ = 1'b0;
      if (op % 2 == 1 && op != 11) begin
        e.dst = if_insn[20:16];
        e.in1 = (op == 7 || op == 9) ? imm_s : imm_u;
      end else begin
        e.dst = if_insn[15:11];
      end
    end else begin
      case (op)
        16, 17, 18, 19: begin
          e.flag = 1'b1;
          e.br   = if_pc + off;
          if (op == 16) e.taken = (a == b);
          if (op == 17) e.taken = (a != b);
          if (op == 18) e.taken = ($signed(a) > $signed(b));
          if (op == 19) e.taken = (a > b);
        end
        20, 21: begin
          e.br = a[31:2]; e.taken = 1'b1; e.flag = 1'b1;
          if (op == 21) begin
            e.in0 = {if_pc + 30'd1, 2'b00}; e.dst = 5'd31; e.we_ = 1'b0;
          end
        end
        22: begin e.alu = 4'd5; e.in1 = imm_s; e.mem = 2'd1; e.dst = if_insn[20:16]; e.we_ = 1'b0; end
        23: begin e.alu = 4'd5; e.in1 = imm_s; e.mem = 2'd2; end
        24: e.exc = 3'd5;
        25, 26, 27: begin
          if (exe_mode) e.exc = 3'd6;
          else if (op == 25) begin e.in0 = creg_rd_data; e.dst = if_insn[20:16]; e.we_ = 1'b0; end
          else if (op == 26) begin e.ctrl = 2'd1; e.dst = if_insn[20:16]; end
          else e.ctrl = 2'd2;
        end
        default: e.exc = 3'd2;
      endcase
    end
    return e;
  endfunction

  // Inputs are set just after a rising edge; this checks combinational outputs,
  // clocks once and compares the registered bundle against the model.
  task automatic step();
    exp_t e;
    #1;
    check("rd_addr_0", {27'd0, gpr_rd_addr_0}, {27'd0, if_insn[25:21]});
    check("rd_addr_1", {27'd0, gpr_rd_addr_1}, {27'd0, if_insn[20:16]});
    check("creg_addr", {27'd0, creg_rd_addr}, {27'd0, if_insn[25:21]});
    check("ld_hazard", {31'd0, ld_hazard}, {31'd0, model_hazard()});
    e = model();
    @(posedge clk);
    #1;
    check("alu_op", {28'd0, alu_op}, {28'd0, e.alu});
    check("alu_in_0", alu_in_0, e.in0);
    check("alu_in_1", alu_in_1, e.in1);
    check("br_addr", {2'd0, br_addr}, {2'd0, e.br});
    check("br_taken", {31'd0, br_taken}, {31'd0, e.taken});
    check("br_flag", {31'd0, br_flag}, {31'd0, e.flag});
    check("mem_op", {30'd0, mem_op}, {30'd0, e.mem});
    check("mem_wr_data", mem_wr_data, e.wr);
    check("ctrl_op", {30'd0, ctrl_op}, {30'd0, e.ctrl});
    check("dst_addr", {27'd0, dst_addr}, {27'd0, e.dst});
    check("gpr_we_", {31'd0, gpr_we_}, {31'd0, e.we_});
    check("exp_code", {29'd0, exp_code}, {29'd0, e.exc});
  endtask

  task automatic idle();
    reset = 1'b0; if_pc = 30'd0; if_insn = 32'd0;
    gpr_rd_data_0 = 32'd0; gpr_rd_data_1 = 32'd0;
    id_en_ = 1'b1; id_gpr_we_ = 1'b1; id_dst_addr = 5'd0; id_mem_op = 2'd0; ex_fwd_data = 32'd0;
    ex_en_ = 1'b1; ex_gpr_we_ = 1'b1; ex_dst_addr = 5'd0; mem_fwd_data = 32'd0;
    exe_mode = 1'b0; creg_rd_data = 32'd0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    check("rst_we", {31'd0, gpr_we_}, 32'd1);
    check("rst_in0", alu_in_0, 32'd0);

    // ADDSI r1 = r0 + 0xFFFF
    idle(); if_insn = {6'h07, 5'd0, 5'd1, 16'hFFFF}; gpr_rd_data_0 = 32'd5;
    step();
    check("addsi_op", {28'd0, alu_op}, 32'd4);
    check("addsi_in0", alu_in_0, 32'd5);
    check("addsi_in1", alu_in_1, 32'hFFFF_FFFF);
    check("addsi_dst", {27'd0, dst_addr}, 32'd1);
    check("addsi_we", {31'd0, gpr_we_}, 32'd0);

    // forwarding: EX beats MEM on ra, MEM alone feeds rb
    idle(); if_insn = {6'h00, 5'd0, 5'd1, 5'd2, 11'd0};
    id_en_ = 1'b0; id_gpr_we_ = 1'b0; id_dst_addr = 5'd0; ex_fwd_data = 32'h99;
    ex_en_ = 1'b0; ex_gpr_we_ = 1'b0; ex_dst_addr = 5'd0; mem_fwd_data = 32'h96;
    step();
    check("fwd_ex", alu_in_0, 32'h99);
    id_en_ = 1'b1; ex_dst_addr = 5'd1; mem_fwd_data = 32'h95;
    step();
    check("fwd_mem", alu_in_1, 32'h95);

    // branches at pc 0
    idle(); if_insn = {6'h10, 5'd0, 5'd0, 16'h0099};
    step();
    check("be_taken", {31'd0, br_taken}, 32'd1);
    check("be_addr", {2'd0, br_addr}, 32'h99);
    idle(); if_insn = {6'h12, 5'd0, 5'd1, 16'h0004}; gpr_rd_data_0 = 32'hFFFF_FFFF;
    step();
    check("bsgt_taken", {31'd0, br_taken}, 32'd0);
    if_insn = {6'h13, 5'd0, 5'd1, 16'h0004};
    step();
    check("bugt_taken", {31'd0, br_taken}, 32'd1);

    // CALL
    idle(); if_pc = 30'd4; if_insn = {6'h15, 5'd3, 5'd0, 16'd0}; gpr_rd_data_0 = 32'h40;
    step();
    check("call_br", {2'd0, br_addr}, 32'h10);
    check("call_in0", alu_in_0, 32'h14);
    check("call_dst", {27'd0, dst_addr}, 32'd31);

    // privileged ops and undefined opcode
    for (int k = 0; k < 3; k++) begin
      idle(); exe_mode = 1'b1; if_insn = {6'h19 + 6'(k), 5'd1, 5'd2, 16'd0};
      step();
      check("prv_vio", {29'd0, exp_code}, 32'd6);
    end
    idle(); if_insn = {6'h19, 5'd1, 5'd2, 16'd0}; creg_rd_data = 32'h99;
    step();
    check("rdcr_in0", alu_in_0, 32'h99);
    idle(); if_insn = {6'h3F, 26'd0};
    step();
    check("undef", {29'd0, exp_code}, 32'd2);

    // load-use stall
    idle(); if_insn = {6'h00, 5'd0, 5'd2, 5'd3, 11'd0};
    id_en_ = 1'b0; id_gpr_we_ = 1'b0; id_mem_op = 2'd1; id_dst_addr = 5'd2;
    #1 check("ld_hz_comb", {31'd0, ld_hazard}, 32'd1);
    step();
    check("ld_hz_we", {31'd0, gpr_we_}, 32'd1);
    check("ld_hz_op", {28'd0, alu_op}, 32'd0);

    // random stream with occasional mid-stream reset
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 24) == 0);
      if_pc         = 30'($urandom);
      if_insn       = $urandom;
      if ($urandom_range(0, 3) != 0) if_insn[31:26] = 6'($urandom_range(0, 27));
      if ($urandom_range(0, 3) != 0) begin
        if_insn[25:21] = 5'($urandom_range(0, 3));
        if_insn[20:16] = 5'($urandom_range(0, 3));
      end
      gpr_rd_data_0 = $urandom;
      gpr_rd_data_1 = ($urandom_range(0, 2) == 0) ? gpr_rd_data_0 : $urandom;
      if ($urandom_range(0, 3) == 0) gpr_rd_data_1 = ~gpr_rd_data_0;
      id_en_        = 1'($urandom_range(0, 1));
      id_gpr_we_    = 1'($urandom_range(0, 1));
      id_dst_addr   = 5'($urandom_range(0, 3));
      id_mem_op     = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'($urandom_range(0, 1) * 2);
      ex_fwd_data   = $urandom;
      ex_en_        = 1'($urandom_range(0, 1));
      ex_gpr_we_    = 1'($urandom_range(0, 1));
      ex_dst_addr   = 5'($urandom_range(0, 3));
      mem_fwd_data  = $urandom;
      exe_mode      = 1'($urandom_range(0, 1));
      creg_rd_data  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
